// File: rtl/dmem_arb_pkg.sv
// Shared types and default parameters for the data-memory arbiter.
package dmem_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} arb_state_t;
  typedef enum logic {OWN_CPU = 1'b0, OWN_DBG = 1'b1} arb_owner_t;

  localparam int DEF_N            = 64;
  localparam int DEF_AW           = 6;
  localparam int DEF_STARVE_LIMIT = 8;
endpackage

// File: rtl/arb_starve_cnt.sv
// Counts IDLE arbitrations lost by the debug requester, saturating at LIMIT.
// Only instantiated when DMEM_ARB_STARVE_EN is defined.
module arb_starve_cnt
  import dmem_arb_pkg::*;
#(
  parameter int LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic dbg_req,
  input  logic dbg_grant,
  output logic starved
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  // With dbg_req high in IDLE an arbitration always happens, so a non-grant is a loss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (idle) begin
      if (!dbg_req || dbg_grant) begin
        cnt <= '0;
      end else if (!starved) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign starved = (cnt == CW'(LIMIT));
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU, debug) data-memory arbiter: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Optional starvation guard for the debug port enabled by DMEM_ARB_STARVE_EN.
// Handshake: a requester holds req and its fields until its ack pulse, then drops req the cycle after.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N            = DEF_N,
  parameter int AW           = DEF_AW,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [N-1:0]  cpu_wdata,
  output logic          cpu_ack,
  output logic [N-1:0]  cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [N-1:0]  dbg_wdata,
  output logic          dbg_ack,
  output logic [N-1:0]  dbg_rdata,
  output logic          mem_we,
  output logic          mem_re,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_wdata,
  input  logic [N-1:0]  mem_rdata,
  output logic          busy
);
  arb_state_t    state;
  arb_owner_t    owner;
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [N-1:0]  lat_wdata;

  logic          starved;
  logic          dbg_wins;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [N-1:0]  win_wdata;

`ifdef DMEM_ARB_STARVE_EN
  arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .reset     (reset),
    .idle      (state == IDLE),
    .dbg_req   (dbg_req),
    .dbg_grant (dbg_wins),
    .starved   (starved)
  );
`else
  // Strict CPU-first priority; the limit is never reached.
  assign starved = (STARVE_LIMIT < 0);
`endif

  assign dbg_wins  = dbg_req & (~cpu_req | starved);
  assign win_we    = dbg_wins ? dbg_we    : cpu_we;
  assign win_addr  = dbg_wins ? dbg_addr  : cpu_addr;
  assign win_wdata = dbg_wins ? dbg_wdata : cpu_wdata;

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign cpu_stall = cpu_req & ~cpu_ack;

  // mem_we is a flop so an asynchronous reset aborts an in-flight store at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= OWN_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
          if (cpu_req || dbg_req) begin
            state     <= ACCESS;
            busy      <= 1'b1;
            owner     <= dbg_wins ? OWN_DBG : OWN_CPU;
            lat_we    <= win_we;
            lat_addr  <= win_addr;
            lat_wdata <= win_wdata;
            mem_we    <= win_we;
            mem_re    <= ~win_we;
          end
        end
        ACCESS: begin
          state  <= RESP;
          mem_we <= 1'b0;
          mem_re <= 1'b0;
          if (owner == OWN_CPU) begin
            cpu_ack <= 1'b1;
            if (!lat_we) cpu_rdata <= mem_rdata;
          end else begin
            dbg_ack <= 1'b1;
            if (!lat_we) dbg_rdata <= mem_rdata;
          end
        end
        RESP: begin
          state   <= IDLE;
          busy    <= 1'b0;
          cpu_ack <= 1'b0;
          dbg_ack <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          mem_we <= 1'b0;
          mem_re <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized two-requester traffic,
// checked every cycle against a transaction-level schedule model and a memory fixture.
module tb_dmem_arbiter;
  localparam int N     = 64;
  localparam int AW    = 6;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dbg_req, dbg_we;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [N-1:0]  cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic          cpu_ack, dbg_ack, cpu_stall, mem_we, mem_re, busy;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  dmem_arbiter #(.N(N), .AW(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // ---------------- memory fixture ----------------
  function automatic logic [N-1:0] init_val(input int a);
    if (a == 5) return 64'h1234;
    return {32'hC0FFEE00 + 32'(a), 32'(a * a) + 32'h5A};
  endfunction

  logic [N-1:0] mem [64];
  logic [63:0]  mem_vld = '0;
  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]     <= mem_wdata;
      mem_vld[mem_addr] <= 1'b1;
    end
  end
  assign mem_rdata = mem_vld[mem_addr] ? mem[mem_addr] : init_val(int'(mem_addr));

  function automatic void chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- scoreboard / reference model ----------------
  // Transaction schedule: a grant at edge g shows the memory op after g, the ack after g+1,
  // and the next grant can be taken no earlier than edge g+3.
  int            n_neg = 0;
  int            acc_n = -10, resp_n = -10, free_e = 0, starve = 0;
  logic          m_own_dbg = 1'b0, m_we = 1'b0, dwin, e_cack, e_dack;
  logic [AW-1:0] m_addr = '0;
  logic [N-1:0]  m_wdata = '0, m_cpu_rdata = '0, m_dbg_rdata = '0, v;
  logic [N-1:0]  exp_q[$];
  logic [N-1:0]  ref_mem[int];

  function automatic logic [N-1:0] ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      acc_n = -10; resp_n = -10; free_e = 0; starve = 0; n_neg = 0;
      m_cpu_rdata = '0; m_dbg_rdata = '0;
      exp_q.delete();
    end else begin
      n_neg++;
      if (resp_n == n_neg) begin
        if (m_we) ref_mem[int'(m_addr)] = m_wdata;
        else if (exp_q.size() > 0) begin
          v = exp_q.pop_front();
          if (m_own_dbg) m_dbg_rdata = v; else m_cpu_rdata = v;
        end
      end
      e_cack = (resp_n == n_neg) && !m_own_dbg;
      e_dack = (resp_n == n_neg) && m_own_dbg;
      chk("cpu_ack", cpu_ack, e_cack);
      chk("dbg_ack", dbg_ack, e_dack);
      chk("mem_we", mem_we, (acc_n == n_neg) && m_we);
      chk("mem_re", mem_re, (acc_n == n_neg) && !m_we);
      chk("busy", busy, (acc_n == n_neg) || (resp_n == n_neg));
      chk("cpu_stall", cpu_stall, cpu_req && !e_cack);
      chk("cpu_rdata", cpu_rdata, m_cpu_rdata);
      chk("dbg_rdata", dbg_rdata, m_dbg_rdata);
      if (acc_n == n_neg) begin
        chk("mem_addr", mem_addr, m_addr);
        if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
      end
      // Arbitration at the coming edge, if the arbiter is free by then.
      if (n_neg + 1 >= free_e) begin
`ifdef DMEM_ARB_STARVE_EN
        dwin = dbg_req && (!cpu_req || starve == LIMIT);
        if (!dbg_req || dwin) starve = 0;
        else if (starve < LIMIT) starve++;
`else
        dwin = dbg_req && !cpu_req;
`endif
        if (cpu_req || dbg_req) begin
          m_own_dbg = dwin;
          m_we      = dwin ? dbg_we : cpu_we;
          m_addr    = dwin ? dbg_addr : cpu_addr;
          m_wdata   = dwin ? dbg_wdata : cpu_wdata;
          if (!m_we) exp_q.push_back(ref_rd(int'(m_addr)));
          acc_n  = n_neg + 1;
          resp_n = n_neg + 2;
          free_e = n_neg + 4;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_drive(input logic we, input int a, input logic [N-1:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = AW'(a); cpu_wdata = d;
  endtask

  task automatic dbg_drive(input logic we, input int a, input logic [N-1:0] d);
    dbg_req = 1'b1; dbg_we = we; dbg_addr = AW'(a); dbg_wdata = d;
  endtask

  task automatic cpu_rand(input int cnt);
    int k;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(1, 4)) step();
      cpu_drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), {$urandom, $urandom});
      k = 0;
      do begin step(); k++; end while (!cpu_ack && k < 60);
      chk("cpu_rand_ack_timeout", !cpu_ack, 1'b0);
      step();
      cpu_req = 1'b0;
    end
  endtask

  task automatic dbg_rand(input int cnt);
    int k;
    for (int i = 0; i < cnt; i++) begin
      repeat ($urandom_range(1, 4)) step();
      dbg_drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), {$urandom, $urandom});
      k = 0;
      do begin step(); k++; end while (!dbg_ack && k < 60);
      chk("dbg_rand_ack_timeout", !dbg_ack, 1'b0);
      step();
      dbg_req = 1'b0;
    end
  endtask

  // ---------------- directed + random sequence ----------------
  int cpu_at, dbg_at, cpu_acks;
  logic got_dbg;

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    repeat (3) step();
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dbg_ack", dbg_ack, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_stall", cpu_stall, 0);
    reset = 1'b1;
    step();

    // CPU load from address 5
    cpu_drive(1'b0, 5, '0);
    #1;
    chk("ld_stall_t", cpu_stall, 1);
    chk("ld_mem_re_pre", mem_re, 0);
    step();
    chk("ld_mem_re_t1", mem_re, 1);
    chk("ld_mem_addr_t1", mem_addr, 5);
    chk("ld_stall_t1", cpu_stall, 1);
    step();
    chk("ld_ack_t2", cpu_ack, 1);
    chk("ld_rdata_t2", cpu_rdata, 64'h1234);
    chk("ld_stall_t2", cpu_stall, 0);
    step();
    cpu_req = 1'b0;
    chk("ld_ack_once", cpu_ack, 0);
    chk("ld_rdata_hold", cpu_rdata, 64'h1234);
    step();

    // Debug store then CPU read-back
    dbg_drive(1'b1, 3, 64'hDEAD);
    step();
    chk("st_mem_we_t1", mem_we, 1);
    chk("st_mem_addr_t1", mem_addr, 3);
    chk("st_mem_wdata_t1", mem_wdata, 64'hDEAD);
    step();
    chk("st_mem_we_once", mem_we, 0);
    chk("st_dbg_ack", dbg_ack, 1);
    chk("st_dbg_rdata_kept", dbg_rdata, 0);
    step();
    dbg_req = 1'b0;
    step();
    cpu_drive(1'b0, 3, '0);
    step(); step();
    chk("rb_ack", cpu_ack, 1);
    chk("rb_rdata", cpu_rdata, 64'hDEAD);
    step();
    cpu_req = 1'b0;
    step();

    // Simultaneous requests: CPU first, debug three cycles later
    cpu_drive(1'b0, 7, '0);
    dbg_drive(1'b0, 9, '0);
    cpu_at = -1; dbg_at = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (cpu_req && cpu_at >= 0) cpu_req = 1'b0;
      if (dbg_req && dbg_at >= 0) dbg_req = 1'b0;
      if (cpu_ack) cpu_at = k;
      if (dbg_ack) dbg_at = k;
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    chk("same_cycle_cpu_ack_at", 64'(cpu_at), 2);
    chk("same_cycle_dbg_ack_at", 64'(dbg_at), 5);
    chk("same_cycle_dbg_rdata", dbg_rdata, init_val(9));
    step();

    // CPU hogging with debug waiting
    cpu_drive(1'b0, 1, '0);
    dbg_drive(1'b0, 2, '0);
    cpu_acks = 0; got_dbg = 1'b0;
    for (int k = 0; k < 60 && !got_dbg; k++) begin
      step();
      if (cpu_ack) cpu_acks++;
      if (dbg_ack) got_dbg = 1'b1;
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
`ifdef DMEM_ARB_STARVE_EN
    chk("starve_dbg_granted", got_dbg, 1);
    chk("starve_cpu_grants_before", 64'(cpu_acks), 8);
`else
    chk("fixed_prio_dbg_never", got_dbg, 0);
    chk("fixed_prio_cpu_grants", 64'(cpu_acks), 20);
`endif
    repeat (4) step();

    // Reset during the ACCESS of a store
    cpu_drive(1'b1, 10, 64'hBAD0BAD0);
    step();
    chk("abort_mem_we_before", mem_we, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("abort_mem_we_drop", mem_we, 0);
    chk("abort_busy", busy, 0);
    cpu_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("abort_no_ack", cpu_ack, 0);
    end
    reset = 1'b1;
    step();
    chk("abort_idle_after", busy, 0);
    cpu_drive(1'b0, 10, '0);
    step(); step();
    chk("abort_mem_unchanged_ack", cpu_ack, 1);
    chk("abort_mem_unchanged", cpu_rdata, init_val(10));
    step();
    cpu_req = 1'b0;
    step();

    // Randomized traffic from both requesters
    fork
      cpu_rand(40);
      dbg_rand(40);
    join
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters SHALL be: N, default 64, data width; AW, default 6, word-address width; STARVE_LIMIT, default 8, consecutive debug losses before a forced debug grant.
REQ-002 Ports SHALL be, as name direction width meaning:
- clk in 1: single clock.
- reset in 1: one clock; reset is asynchronous and active-low.
- cpu_req in 1: CPU memory request.
- cpu_we in 1: 1 for store, 0 for load.
- cpu_addr in AW: word address.
- cpu_wdata in N: store data.
- cpu_ack out 1: one-cycle completion pulse.
- cpu_rdata out N: load data.
- cpu_stall out 1: pipeline stall.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: debug/dump requester; same widths and meanings as the cpu_ ports.
- mem_we out 1, mem_re out 1, mem_addr out AW, mem_wdata out N: data-memory drive.
- mem_rdata in N: combinational read data from data memory.
- busy out 1: FSM not in IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS and RESP; transitions are IDLE->ACCESS when any req is high, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-004 In IDLE the arbiter SHALL latch the winner's we/addr/wdata and a grant-owner bit.
REQ-005 Arbitration SHALL be: CPU wins over debug, except when the starvation count equals STARVE_LIMIT, in which case debug wins.
REQ-006 In ACCESS, mem_addr and mem_wdata SHALL come from the latched values, with mem_we = latched we and mem_re = !latched we; mem_we and mem_re SHALL be 0 in all other states.
REQ-007 At the end of ACCESS the arbiter SHALL register mem_rdata into the owner's rdata register; the other requester's rdata SHALL hold its value.
REQ-008 In RESP the arbiter SHALL pulse the owner's ack for exactly one cycle; rdata SHALL be valid in that cycle and SHALL hold until that requester's next ack.
REQ-009 Handshake: a requester SHALL hold req and its fields stable until ack and drop req in the cycle after ack; the arbiter SHALL ignore all req inputs in ACCESS and RESP.
REQ-010 Latency SHALL be a fixed 3 cycles from req sampled high in IDLE to ack (edges t, t+1, t+2); throughput SHALL be one access per 3 cycles.
REQ-011 cpu_stall SHALL equal cpu_req & !cpu_ack, combinationally.
REQ-012 When cpu_req and dbg_req rise in the same IDLE cycle, REQ-005 SHALL decide the winner; the loser SHALL be served in the next IDLE cycle, 3 cycles later.
REQ-013 A write SHALL produce an ack and SHALL leave that requester's rdata unchanged.

Reset
REQ-014 On reset low, asynchronously: state IDLE; ack, mem_we, mem_re and busy 0; rdata registers 0; latched fields 0; starvation count 0.
REQ-015 If reset is asserted during ACCESS, the memory write SHALL be aborted (mem_we falls asynchronously) and no ack SHALL be issued.

Configuration
REQ-016 Macro DMEM_ARB_STARVE_EN: when defined, the starvation counter SHALL count IDLE arbitrations that debug loses while dbg_req is high, saturating at STARVE_LIMIT, and SHALL clear on a debug grant or when dbg_req is low in IDLE.
REQ-017 When DMEM_ARB_STARVE_EN is not defined, the counter SHALL be absent and priority SHALL be strictly fixed (CPU first), so debug can starve.

Structure
REQ-018 Package dmem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/RESP), the owner enum (OWN_CPU/OWN_DBG) and the default parameter constants.
REQ-019 The starvation counter SHALL be sub-module arb_starve_cnt, instantiated only under DMEM_ARB_STARVE_EN.

Verification
REQ-020 CPU load, addr 5, mem[5]=0x1234 -> mem_re high at t+1, cpu_ack at t+2, cpu_rdata=0x1234, cpu_stall high for t..t+1.
REQ-021 Debug store, addr 3, data 0xDEAD -> mem_we high for exactly one cycle at t+1 with mem_addr=3, then dbg_ack; a later load of addr 3 returns 0xDEAD.
REQ-022 cpu_req and dbg_req rise in the same cycle -> CPU acked at t+2, debug acked at t+5.
REQ-023 With the macro defined, CPU re-requests continuously and dbg_req held high -> debug is granted after 8 CPU grants; with the macro undefined, debug is never granted.
REQ-024 Reset asserted in the ACCESS of a store -> mem_we drops immediately, no ack, memory unchanged, FSM in IDLE after release.
